// File: rtl/ppg_ratio_calc_if.sv
// Sample/result bundle between the oximeter front-end and the SpO2 ratio stage.
// master = front-end side (drives samples), slave = ratio calculator.
interface ppg_ratio_calc_if #(
  parameter int RATIO_W = 10
);
  logic               enable;
  logic [7:0]         red_sample;
  logic               red_valid;
  logic [7:0]         ir_sample;
  logic               ir_valid;
  logic [7:0]         red_ac;
  logic [7:0]         red_dc;
  logic [7:0]         ir_ac;
  logic [7:0]         ir_dc;
  logic [RATIO_W-1:0] ratio;
  logic               ratio_valid;
  logic               err_div0;
  logic               busy;

  modport master (
    output enable, red_sample, red_valid, ir_sample, ir_valid,
    input  red_ac, red_dc, ir_ac, ir_dc, ratio, ratio_valid, err_div0, busy
  );

  modport slave (
    input  enable, red_sample, red_valid, ir_sample, ir_valid,
    output red_ac, red_dc, ir_ac, ir_dc, ratio, ratio_valid, err_div0, busy
  );
endinterface

// File: rtl/ppg_ratio_calc.sv
// Windowed min/max tracking per PPG channel and SpO2 ratio-of-ratios via a restoring divider.
// Define RATIO_IIR_EN to IIR-smooth the ratio output (alpha = 1/4).
module ppg_ratio_calc #(
  parameter int WINDOW  = 256,
  parameter int FRAC    = 7,
  parameter int RATIO_W = 10
) (
  input logic             CLK,
  input logic             rst_n,
  ppg_ratio_calc_if.slave bus
);
  localparam int DIV_N = 16 + FRAC;
  localparam int IT_W  = $clog2(DIV_N + 1);
  localparam logic [9:0] WIN = 10'(WINDOW);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ACQ  = 3'd1;
  localparam logic [2:0] S_MULT = 3'd2;
  localparam logic [2:0] S_DIV  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]       state;
  logic [7:0]       red_min, red_max, ir_min, ir_max;
  logic [9:0]       red_cnt, ir_cnt;
  logic [DIV_N-1:0] dvd;
  logic [DIV_N-2:0] quo;
  logic [15:0]      rem, den;
  logic [IT_W-1:0]  it;

  logic             red_acc, ir_acc, win_full;
  logic [8:0]       red_sum, ir_sum;
  logic [7:0]       red_ac_n, red_dc_n, ir_ac_n, ir_dc_n;
  logic [15:0]      num_n, den_n;
  logic [16:0]      trial;
  logic             ge, last_it, sat;
  logic [15:0]      rem_n;
  logic [DIV_N-1:0] quo_n;
  logic [RATIO_W-1:0] raw;

  // A channel that already holds WINDOW samples waits for the other one.
  assign red_acc  = (state == S_ACQ) && bus.red_valid && (red_cnt != WIN);
  assign ir_acc   = (state == S_ACQ) && bus.ir_valid && (ir_cnt != WIN);
  assign win_full = (red_cnt == WIN) && (ir_cnt == WIN);

  assign red_ac_n = red_max - red_min;
  assign ir_ac_n  = ir_max - ir_min;
  assign red_sum  = {1'b0, red_max} + {1'b0, red_min};
  assign ir_sum   = {1'b0, ir_max} + {1'b0, ir_min};
  assign red_dc_n = 8'(red_sum >> 1);
  assign ir_dc_n  = 8'(ir_sum >> 1);
  assign num_n    = 16'(red_ac_n) * 16'(ir_dc_n);
  assign den_n    = 16'(ir_ac_n) * 16'(red_dc_n);

  // One restoring step: the partial remainder is always < den, so 16 bits hold it.
  assign trial   = {rem, dvd[DIV_N-1]};
  assign ge      = trial >= {1'b0, den};
  assign rem_n   = ge ? 16'(trial - {1'b0, den}) : trial[15:0];
  assign quo_n   = {quo, ge};
  assign last_it = (it == IT_W'(DIV_N - 1));
  assign sat     = (|quo_n[DIV_N-1:RATIO_W]) || (den == 16'd0);
  assign raw     = sat ? '1 : quo_n[RATIO_W-1:0];

  assign bus.busy = (state == S_MULT) || (state == S_DIV) || (state == S_DONE);

`ifdef RATIO_IIR_EN
  logic [RATIO_W-1:0]   hist;
  logic                 have_hist;
  logic signed [RATIO_W:0] diff, filt;

  assign diff = $signed({1'b0, raw}) - $signed({1'b0, hist});
  assign filt = $signed({1'b0, hist}) + (diff >>> 2);
`endif

  // NOTE: all state here is sequential, so it is written with <= only; blocking
  // assignments would make later reads in this block see same-cycle values.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      red_min         <= 8'hFF;
      red_max         <= 8'h00;
      ir_min          <= 8'hFF;
      ir_max          <= 8'h00;
      red_cnt         <= '0;
      ir_cnt          <= '0;
      dvd             <= '0;
      quo             <= '0;
      rem             <= '0;
      den             <= '0;
      it              <= '0;
      bus.red_ac      <= '0;
      bus.red_dc      <= '0;
      bus.ir_ac       <= '0;
      bus.ir_dc       <= '0;
      bus.ratio       <= '0;
      bus.ratio_valid <= 1'b0;
      bus.err_div0    <= 1'b0;
`ifdef RATIO_IIR_EN
      hist            <= '0;
      have_hist       <= 1'b0;
`endif
    end else begin
      bus.ratio_valid <= 1'b0;
      if (!bus.enable) begin
        // Drop the window and any division in flight; result outputs hold.
        state   <= S_IDLE;
        red_min <= 8'hFF;
        red_max <= 8'h00;
        ir_min  <= 8'hFF;
        ir_max  <= 8'h00;
        red_cnt <= '0;
        ir_cnt  <= '0;
        it      <= '0;
`ifdef RATIO_IIR_EN
        have_hist <= 1'b0;
`endif
      end else begin
        case (state)
          S_IDLE: state <= S_ACQ;
          S_ACQ: begin
            if (red_acc) begin
              if (bus.red_sample < red_min) red_min <= bus.red_sample;
              if (bus.red_sample > red_max) red_max <= bus.red_sample;
              red_cnt <= red_cnt + 10'd1;
            end
            if (ir_acc) begin
              if (bus.ir_sample < ir_min) ir_min <= bus.ir_sample;
              if (bus.ir_sample > ir_max) ir_max <= bus.ir_sample;
              ir_cnt <= ir_cnt + 10'd1;
            end
            if (win_full) state <= S_MULT;
          end
          S_MULT: begin
            bus.red_ac <= red_ac_n;
            bus.red_dc <= red_dc_n;
            bus.ir_ac  <= ir_ac_n;
            bus.ir_dc  <= ir_dc_n;
            dvd        <= {num_n, {FRAC{1'b0}}};
            den        <= den_n;
            rem        <= '0;
            quo        <= '0;
            it         <= '0;
            red_min    <= 8'hFF;
            red_max    <= 8'h00;
            ir_min     <= 8'hFF;
            ir_max     <= 8'h00;
            red_cnt    <= '0;
            ir_cnt     <= '0;
            state      <= S_DIV;
          end
          S_DIV: begin
            dvd <= dvd << 1;
            rem <= rem_n;
            quo <= quo_n[DIV_N-2:0];
            it  <= it + IT_W'(1);
            if (last_it) begin
              state           <= S_DONE;
              bus.ratio_valid <= 1'b1;
              bus.err_div0    <= (den == 16'd0);
`ifdef RATIO_IIR_EN
              // Saturated/div0 results bypass the filter and leave its history alone.
              if (sat) begin
                bus.ratio <= raw;
              end else if (!have_hist) begin
                bus.ratio <= raw;
                hist      <= raw;
                have_hist <= 1'b1;
              end else begin
                bus.ratio <= RATIO_W'(filt);
                hist      <= RATIO_W'(filt);
              end
`else
              bus.ratio <= raw;
`endif
            end
          end
          S_DONE:  state <= S_ACQ;
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ppg_ratio_calc.sv
// Self-checking bench for ppg_ratio_calc: arithmetic window model, one compare process
// on every ratio_valid pulse, plus hand-computed literal expectations.
module tb_ppg_ratio_calc;
  localparam int WIN  = 4;
  localparam int FRAC = 7;
  localparam int RW   = 10;
  localparam int LAT  = 18 + FRAC;
`ifdef RATIO_IIR_EN
  localparam int IIR_W2 = 95;
`else
  localparam int IIR_W2 = 128;
`endif

  typedef logic [7:0] win_t [4];
  typedef struct {
    int red_ac, red_dc, ir_ac, ir_dc, ratio, err, cyc;
  } exp_t;

  logic CLK   = 1'b0;
  logic rst_n = 1'b1;
  always #5 CLK = ~CLK;

  ppg_ratio_calc_if #(.RATIO_W(RW)) bus ();

  ppg_ratio_calc #(.WINDOW(WIN), .FRAC(FRAC), .RATIO_W(RW)) dut (
    .CLK  (CLK),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int   tests = 0;
  int   fails = 0;
  int   cyc;
  int   last_cyc;
  exp_t exp_q[$];
  exp_t e;
  int   hist;
  bit   have_hist;
  int   last_ratio, last_err;

  always @(posedge CLK or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expected results from the window contents using plain integer arithmetic.
  task automatic push_exp(input win_t r, input win_t ir);
    exp_t x;
    int rmin = 255, rmax = 0, imin = 255, imax = 0;
    int num, den, q, d, sat;
    for (int i = 0; i < 4; i++) begin
      if (r[i] < rmin) rmin = r[i];
      if (r[i] > rmax) rmax = r[i];
      if (ir[i] < imin) imin = ir[i];
      if (ir[i] > imax) imax = ir[i];
    end
    x.red_ac = rmax - rmin;
    x.red_dc = (rmax + rmin) / 2;
    x.ir_ac  = imax - imin;
    x.ir_dc  = (imax + imin) / 2;
    num = x.red_ac * x.ir_dc;
    den = x.ir_ac * x.red_dc;
    if (den == 0) begin
      x.err = 1; sat = 1; q = 1023;
    end else begin
      x.err = 0;
      q = (num * (1 << FRAC)) / den;
      sat = (q > 1023);
      if (sat) q = 1023;
    end
`ifdef RATIO_IIR_EN
    if (sat) x.ratio = q;
    else if (!have_hist) begin
      x.ratio = q; hist = q; have_hist = 1;
    end else begin
      d = q - hist;
      x.ratio = hist + ((d >= 0) ? d / 4 : -((-d + 3) / 4));
      hist = x.ratio;
    end
`else
    d = 0;
    x.ratio = q;
`endif
    x.cyc = last_cyc;
    last_ratio = x.ratio;
    last_err   = x.err;
    exp_q.push_back(x);
  endtask

  // Called at posedge+1; the strobe is accepted by the next posedge, then one idle cycle.
  task automatic send(input logic rv, input logic [7:0] rs, input logic iv, input logic [7:0] irs);
    bus.red_valid = rv; bus.red_sample = rs;
    bus.ir_valid  = iv; bus.ir_sample  = irs;
    @(posedge CLK); #1;
    last_cyc = cyc;
    bus.red_valid = 1'b0; bus.ir_valid = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic window(input win_t r, input win_t ir, input bit together, input bit push);
    if (together) begin
      for (int i = 0; i < 4; i++) send(1'b1, r[i], 1'b1, ir[i]);
    end else begin
      for (int i = 0; i < 4; i++) send(1'b1, r[i], 1'b0, 8'd0);
      for (int i = 0; i < 4; i++) send(1'b0, 8'd0, 1'b1, ir[i]);
    end
    if (push) push_exp(r, ir);
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge CLK);
    check({name, "_timeout"}, exp_q.size(), 0);
    exp_q.delete();
    @(negedge CLK);
  endtask

  // Compare process: every ratio_valid pulse must match the oldest expected window.
  always @(negedge CLK) begin
    if (rst_n && bus.ratio_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("latency",   cyc,         e.cyc + LAT);
        check("red_ac",    bus.red_ac,  e.red_ac);
        check("red_dc",    bus.red_dc,  e.red_dc);
        check("ir_ac",     bus.ir_ac,   e.ir_ac);
        check("ir_dc",     bus.ir_dc,   e.ir_dc);
        check("ratio",     bus.ratio,   e.ratio);
        check("err_div0",  bus.err_div0, e.err);
        check("busy_done", bus.busy,    1);
      end
    end
  end

  win_t s1r = '{100, 140, 120, 110};
  win_t s1i = '{60, 100, 80, 90};
  win_t s2  = '{60, 100, 80, 90};
  win_t icn = '{50, 50, 50, 50};
  win_t s3r = '{0, 200, 0, 200};
  win_t s3i = '{100, 101, 100, 101};

  initial begin
    bus.enable = 1'b0; bus.red_valid = 1'b0; bus.ir_valid = 1'b0;
    bus.red_sample = '0; bus.ir_sample = '0;
    have_hist = 0; hist = 0; last_ratio = 0; last_err = 0; last_cyc = 0;

    #2 rst_n = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_ratio", bus.ratio, 0);
    check("rst_valid", bus.ratio_valid, 0);
    check("rst_err",   bus.err_div0, 0);
    check("rst_busy",  bus.busy, 0);
    check("rst_red_ac", bus.red_ac, 0);
    check("rst_ir_dc",  bus.ir_dc, 0);
    @(posedge CLK); #1 rst_n = 1'b1;
    bus.enable = 1'b1;
    repeat (2) @(posedge CLK); #1;

    // Basic window: R = 3200*128/4800
    window(s1r, s1i, 1'b0, 1'b1);
    wait_done("w1");
    check("w1_ratio", bus.ratio, 85);
    check("w1_red_ac", bus.red_ac, 40);
    check("w1_red_dc", bus.red_dc, 120);
    check("w1_ir_ac", bus.ir_ac, 40);
    check("w1_ir_dc", bus.ir_dc, 80);
    check("w1_err", bus.err_div0, 0);
    @(posedge CLK); #1;

    // Flat IR: zero denominator
    window(s1r, icn, 1'b1, 1'b1);
    wait_done("div0");
    check("div0_ratio", bus.ratio, 1023);
    check("div0_err", bus.err_div0, 1);
    @(posedge CLK); #1;

    window(s1r, s1i, 1'b0, 1'b1);
    wait_done("clr");
    check("clr_err", bus.err_div0, 0);
    check("clr_ratio", bus.ratio, 85);
    @(posedge CLK); #1;

    // Quotient 25600 overflows the output width
    window(s3r, s3i, 1'b1, 1'b1);
    wait_done("sat");
    check("sat_ratio", bus.ratio, 1023);
    check("sat_err", bus.err_div0, 0);
    @(posedge CLK); #1;

    // Fifth RED and RED alongside IR are ignored once RED is full
    for (int i = 0; i < 4; i++) send(1'b1, s1r[i], 1'b0, 8'd0);
    send(1'b1, 8'd250, 1'b0, 8'd0);
    send(1'b0, 8'd0, 1'b1, s1i[0]);
    send(1'b1, 8'd5, 1'b1, s1i[1]);
    send(1'b0, 8'd0, 1'b1, s1i[2]);
    send(1'b0, 8'd0, 1'b1, s1i[3]);
    push_exp(s1r, s1i);
    // These land in MULT/DIV and must not reach the next window
    for (int i = 0; i < 3; i++) send(1'b1, 8'd0, 1'b1, 8'd255);
    wait_done("extra");
    check("extra_red_ac", bus.red_ac, 40);
    check("extra_red_dc", bus.red_dc, 120);
    @(posedge CLK); #1;
    window(s2, s2, 1'b1, 1'b1);
    wait_done("after_div");
    check("ad_red_ac", bus.red_ac, 40);
    check("ad_red_dc", bus.red_dc, 80);
    check("ad_ir_ac", bus.ir_ac, 40);
    check("ad_ir_dc", bus.ir_dc, 80);
    @(posedge CLK); #1;

    // Enable dropped mid-DIV: no pulse, ratio and err hold
    window(s3r, s3i, 1'b1, 1'b0);
    repeat (8) @(posedge CLK); #1;
    bus.enable = 1'b0;
    have_hist = 0;
    repeat (40) @(posedge CLK);
    @(negedge CLK);
    check("abort_ratio", bus.ratio, last_ratio);
    check("abort_err", bus.err_div0, last_err);
    check("abort_busy", bus.busy, 0);
    @(posedge CLK); #1 bus.enable = 1'b1;
    repeat (2) @(posedge CLK); #1;
    window(s1r, s1i, 1'b0, 1'b1);
    wait_done("resume");
    check("resume_ratio", bus.ratio, 85);
    @(posedge CLK); #1;

    // Async reset mid-DIV clears outputs without waiting for a clock edge
    window(s3r, s3i, 1'b1, 1'b0);
    repeat (8) @(posedge CLK); #1;
    rst_n = 1'b0;
    have_hist = 0;
    #1;
    check("arst_ratio", bus.ratio, 0);
    check("arst_red_ac", bus.red_ac, 0);
    check("arst_red_dc", bus.red_dc, 0);
    check("arst_ir_ac", bus.ir_ac, 0);
    check("arst_ir_dc", bus.ir_dc, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_valid", bus.ratio_valid, 0);
    repeat (2) @(posedge CLK); #1 rst_n = 1'b1;
    repeat (2) @(posedge CLK); #1;

    // Two windows after reset: second is smoothed when the filter is built in
    window(s1r, s1i, 1'b0, 1'b1);
    wait_done("iir1");
    check("iir1_ratio", bus.ratio, 85);
    @(posedge CLK); #1;
    window(s2, s2, 1'b0, 1'b1);
    wait_done("iir2");
    check("iir2_ratio", bus.ratio, IIR_W2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ppg_ratio_calc.md
Name: ppg_ratio_calc

Overview:
- Downstream consumer of the oximeter front-end controller's per-phase outputs: the RED and IR ADC sample values, each with a strobe.
- Over a window of WINDOW samples per channel, tracks min/max per channel and derives AC amplitude and DC level.
- Computes the SpO2 ratio-of-ratios R = (AC_red*DC_ir)/(AC_ir*DC_red) as unsigned fixed point, using a sequential restoring divider.
- Feeds the SpO2 lookup stage.

Parameters:
- WINDOW, 256: samples per channel per window (2..1023).
- FRAC, 7: fractional bits of the ratio.
- RATIO_W, 10: ratio output width, unsigned Q(RATIO_W-FRAC).FRAC.

Ports:
- CLK  input  1  clock; all logic on posedge.
- rst_n  input  1  reset, asynchronous, active-low.
- enable  input  1  high once front-end calibration is complete; low forces IDLE.
- red_sample  input  8  RED ADC value.
- red_valid  input  1  single-cycle strobe qualifying red_sample.
- ir_sample  input  8  IR ADC value.
- ir_valid  input  1  single-cycle strobe qualifying ir_sample.
- red_ac  output  8  max-min of last RED window.
- red_dc  output  8  (max+min)>>1 of last RED window.
- ir_ac  output  8  same, IR.
- ir_dc  output  8  same, IR.
- ratio  output  RATIO_W  R, saturated.
- ratio_valid  output  1  one-cycle pulse, new ratio/AC/DC valid.
- err_div0  output  1  denominator of last computation was zero; sticky until next ratio_valid.
- busy  output  1  high in MULT, DIV, DONE.

Behaviour:
- Reset: all outputs 0; state IDLE; min regs 255, max regs 0; counters 0.
- States:
  - IDLE -> ACQ when enable=1.
  - ACQ -> MULT when both channel counters equal WINDOW.
  - MULT -> DIV after 1 cycle.
  - DIV -> DONE after 16+FRAC cycles.
  - DONE -> ACQ after 1 cycle.
  - enable=0 in any state -> IDLE next edge: min/max/counters cleared, divider abandoned, outputs hold last values, no ratio_valid.
- ACQ:
  - Each strobe updates that channel's min/max and increments its counter.
  - A channel whose counter = WINDOW ignores further strobes until the other channel completes.
  - Simultaneous red_valid and ir_valid are both accepted.
- Strobes in IDLE, MULT, DIV, DONE are dropped.
- MULT edge:
  - Latch red_ac/red_dc/ir_ac/ir_dc outputs; ac = max-min (8b); dc = 9-bit sum >>1.
  - num = red_ac*ir_dc (16b); den = ir_ac*red_dc (16b).
  - Clear min/max/counters for the next window.
- DIV:
  - Restoring division of {num, FRAC zeros} by den, one quotient bit per cycle, MSB first, 16+FRAC iterations. Quotient is truncated (floor).
  - If any quotient bit above RATIO_W-1 is set, ratio = 2^RATIO_W-1.
  - If den=0, ratio = 2^RATIO_W-1 and err_div0 = 1; otherwise err_div0 = 0.
- DONE: ratio register written, ratio_valid = 1 for exactly one cycle.
- Latency: ratio_valid is high in the cycle following edge 18+FRAC after the edge that accepted the window-completing sample (25 edges at defaults).
- No window overlap; a sample arriving on the completing edge of the other channel counts toward the current window.
- Async reset mid-DIV: immediate return to reset values.

Optional Feature:
RATIO_IIR_EN:
- Defined: output ratio is IIR-smoothed.
  - First ratio after reset or after IDLE loads directly.
  - Thereafter ratio <= ratio + ((new - ratio) >>> 2), computed signed with RATIO_W+1 bits; result stays in range.
  - Applied in DONE; latency unchanged.
  - Saturated or div0 results load directly and do not update the filter history.
- Undefined: ratio = raw quotient.

Test Plan:
- WINDOW=4, enable=1:
  - RED 100,140,120,110 -> red_ac=40, red_dc=120.
  - IR 60,100,80,90 -> ir_ac=40, ir_dc=80.
  - ratio=85 (3200*128/4800), err_div0=0, ratio_valid 25 edges after the last accepted strobe.
- IR constant 50 (ir_ac=0), RED as above -> ratio=1023, err_div0=1; the next normal window clears err_div0.
- RED 0,200,0,200 (ac=200, dc=100); IR 100,101,100,101 (ac=1, dc=100) -> quotient 25600 saturates, ratio=1023, err_div0=0.
- Five RED strobes before any IR, then 4 IR (simultaneous with RED on one cycle) -> 5th RED ignored, window uses the first 4; strobes during DIV dropped, verified by the next window's min/max.
- Deassert enable mid-DIV -> no ratio_valid, outputs hold; reassert enable -> fresh window correct. Assert rst_n=0 mid-DIV -> all outputs 0 immediately.
- RATIO_IIR_EN, two windows:
  - Window 1 = first scenario -> ratio=85.
  - Window 2, RED and IR both 60,100,80,90 -> raw 128, output ratio=95.
